// File: rtl/fu_wb_buffer_if.sv
// Result packet type and FU-to-CDB writeback handshake bundle.
// Latency: none; this file only declares types and wiring.
// Backpressure: in_ready toward the FU and cdb_stall from the CDB travel through here.
package fu_wb_pkg;
    typedef struct packed {
        logic [31:0] decoded_vals;
        logic [31:0] result;
    } fu_packet_t;
endpackage

interface fu_wb_if #(parameter int DEPTH = 4);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   squash;
    logic                   in_valid;
    fu_wb_pkg::fu_packet_t  in_packet;
    logic                   in_ready;
    logic                   out_done;
    fu_wb_pkg::fu_packet_t  out_packet;
    logic                   cdb_stall;
    logic [CNT_W-1:0]       count;

    // Buffer side
    modport slave (
        input  squash, in_valid, in_packet, cdb_stall,
        output in_ready, out_done, out_packet, count
    );

    // FU / CDB side
    modport master (
        output squash, in_valid, in_packet, cdb_stall,
        input  in_ready, out_done, out_packet, count
    );
endinterface

// File: rtl/fu_wb_buffer.sv
// Per-FU writeback FIFO: holds finished results until the CDB arbiter grants them.
// Latency: 1 cycle from in_valid to out_done (no bypass); strict FIFO order.
// Backpressure: in_ready is registered (count < DEPTH); cdb_stall holds the head entry.
module fu_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    fu_wb_if.slave  bus
);
    import fu_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    fu_packet_t         mem_q [DEPTH];
    fu_packet_t         mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_done_w;
    logic               in_ready_w;
    logic               enq;
    logic               deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outputs depend on registered state only, so nothing from the inputs leaks through.
    always_comb begin
        out_done_w     = (count_q != '0);
        in_ready_w     = (count_q < CNT_W'(DEPTH));
        bus.out_done   = out_done_w;
        bus.in_ready   = in_ready_w;
        bus.count      = count_q;
        bus.out_packet = out_done_w ? mem_q[head_q] : '0;
    end

    // Next-state: enqueue/dequeue bookkeeping; squash overrides pointers and count.
    always_comb begin
        enq     = bus.in_valid & in_ready_w & ~bus.squash;
        deq     = out_done_w & ~bus.cdb_stall;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            mem_d[tail_q] = bus.in_packet;
            tail_d        = ptr_inc(tail_q);
        end
        if (deq) begin
            head_d = ptr_inc(head_q);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A grant this cycle was already broadcast; only the bookkeeping is discarded.
        if (bus.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are masked by count, so it needs no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Structural invariants of the circular buffer.
    always @(posedge clock) begin
        if (reset) begin
            assert (int'(count_q) <= DEPTH);
            assert (!(enq && (int'(count_q) == DEPTH)));
            assert (int'(tail_q) == ((int'(head_q) + int'(count_q)) % DEPTH));
        end
    end
endmodule

// File: tb/tb_fu_wb_buffer.sv
// Directed bench for the writeback FIFO at DEPTH=4 and DEPTH=3.
// Latency: checks enqueue-to-done timing, grant/enqueue overlap, squash and async reset.
// Backpressure: exercises full-buffer refusal and randomly stalled CDB grants.
module tb_fu_wb_buffer;
    import fu_wb_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    fu_wb_if #(.DEPTH(4)) i4 ();
    fu_wb_if #(.DEPTH(3)) i3 ();

    fu_wb_buffer #(.DEPTH(4)) u4 (.clock(clock), .reset(reset), .bus(i4.slave));
    fu_wb_buffer #(.DEPTH(3)) u3 (.clock(clock), .reset(reset), .bus(i3.slave));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic fu_packet_t mk(input logic [31:0] r);
        fu_packet_t p;
        p.decoded_vals = 32'hD000_0000 | r;
        p.result       = r;
        return p;
    endfunction

    task automatic push4(input logic [31:0] r);
        i4.in_valid  = 1'b1;
        i4.in_packet = mk(r);
        tick();
        i4.in_valid  = 1'b0;
    endtask

    fu_packet_t q3[$];
    fu_packet_t pkt;
    int  sent;
    int  rcvd;
    logic exp_enq;
    logic exp_deq;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        i4.squash = 1'b0; i4.in_valid = 1'b0; i4.in_packet = '0; i4.cdb_stall = 1'b0;
        i3.squash = 1'b0; i3.in_valid = 1'b0; i3.in_packet = '0; i3.cdb_stall = 1'b0;

        // Reset state
        #12;
        chk("rst_done",  64'(i4.out_done), 64'(0));
        chk("rst_count", 64'(i4.count), 64'(0));
        chk("rst_ready", 64'(i4.in_ready), 64'(1));
        chk("rst_pkt",   64'(i4.out_packet), 64'(0));
        chk("rst3_rdy",  64'(i3.in_ready), 64'(1));
        @(posedge clock);
        #1 reset = 1'b1;

        // Single result through an empty buffer: no bypass, one cycle of done
        i4.in_valid  = 1'b1;
        i4.in_packet = mk(32'h1234);
        #1;
        chk("t2_nobyp", 64'(i4.out_done), 64'(0));
        tick();
        i4.in_valid = 1'b0;
        chk("t2_done",  64'(i4.out_done), 64'(1));
        chk("t2_res",   64'(i4.out_packet.result), 64'h1234);
        chk("t2_cnt1",  64'(i4.count), 64'(1));
        tick();
        chk("t2_done0", 64'(i4.out_done), 64'(0));
        chk("t2_cnt0",  64'(i4.count), 64'(0));

        // Fill under stall, refuse a fifth, then drain in order
        i4.cdb_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_rdy", 64'(i4.in_ready), 64'(1));
            push4(32'(k));
        end
        chk("t3_full_rdy", 64'(i4.in_ready), 64'(0));
        chk("t3_full_cnt", 64'(i4.count), 64'(4));
        i4.in_valid  = 1'b1;
        i4.in_packet = mk(32'd5);
        tick();
        chk("t3_cnt_hold", 64'(i4.count), 64'(4));
        chk("t3_head",     64'(i4.out_packet.result), 64'(1));
        i4.cdb_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) chk("t3_norelease", 64'(i4.in_ready), 64'(0));
            chk("t3_drain_done", 64'(i4.out_done), 64'(1));
            chk("t3_drain_res",  64'(i4.out_packet), 64'(mk(32'(k))));
            i4.in_valid = 1'b0;
            tick();
        end
        chk("t3_empty", 64'(i4.count), 64'(0));

        // Enqueue and grant in the same cycle at count=1
        i4.cdb_stall = 1'b1;
        push4(32'd6);
        chk("t4_cnt1", 64'(i4.count), 64'(1));
        chk("t4_res6", 64'(i4.out_packet.result), 64'(6));
        i4.cdb_stall = 1'b0;
        push4(32'd7);
        chk("t4_cnt_same", 64'(i4.count), 64'(1));
        chk("t4_res7",     64'(i4.out_packet.result), 64'(7));
        tick();
        chk("t4_cnt0", 64'(i4.count), 64'(0));

        // Squash with two held, an incoming packet and a grant
        i4.cdb_stall = 1'b1;
        push4(32'h61);
        push4(32'h62);
        chk("t6_cnt2", 64'(i4.count), 64'(2));
        i4.cdb_stall = 1'b0;
        i4.squash    = 1'b1;
        i4.in_valid  = 1'b1;
        i4.in_packet = mk(32'h63);
        #1;
        chk("t6_bcast_done", 64'(i4.out_done), 64'(1));
        chk("t6_bcast_res",  64'(i4.out_packet.result), 64'h61);
        tick();
        i4.squash   = 1'b0;
        i4.in_valid = 1'b0;
        chk("t6_cnt0",  64'(i4.count), 64'(0));
        chk("t6_done0", 64'(i4.out_done), 64'(0));
        chk("t6_pkt0",  64'(i4.out_packet), 64'(0));
        tick();
        chk("t6_dropped", 64'(i4.count), 64'(0));

        // Asynchronous reset mid-run with three held
        i4.cdb_stall = 1'b1;
        push4(32'hA1);
        push4(32'hA2);
        push4(32'hA3);
        chk("t1_cnt3", 64'(i4.count), 64'(3));
        #2 reset = 1'b0;
        #1;
        chk("t1_done", 64'(i4.out_done), 64'(0));
        chk("t1_cnt",  64'(i4.count), 64'(0));
        chk("t1_rdy",  64'(i4.in_ready), 64'(1));
        chk("t1_pkt",  64'(i4.out_packet), 64'(0));
        #1 reset = 1'b1;
        i4.cdb_stall = 1'b0;
        tick();
        chk("t1_still0", 64'(i4.count), 64'(0));

        // DEPTH=3 wrap-around with random stalls against a queue model
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
            pkt          = '{decoded_vals: 32'h300 + 32'(sent), result: 32'hA00 + 32'(sent)};
            i3.in_valid  = (sent < 10);
            i3.in_packet = pkt;
            i3.cdb_stall = 1'($urandom_range(0, 1));
            #1;
            chk("w_cnt",  64'(i3.count), 64'(q3.size()));
            chk("w_rdy",  64'(i3.in_ready), 64'(q3.size() < 3));
            chk("w_done", 64'(i3.out_done), 64'(q3.size() != 0));
            if (q3.size() != 0) chk("w_data", 64'(i3.out_packet), 64'(q3[0]));
            exp_deq = (q3.size() != 0) && !i3.cdb_stall;
            exp_enq = (sent < 10) && (q3.size() < 3);
            @(posedge clock);
            #1;
            if (exp_deq) begin
                void'(q3.pop_front());
                rcvd++;
            end
            if (exp_enq) begin
                q3.push_back(pkt);
                sent++;
            end
        end
        i3.in_valid  = 1'b0;
        i3.cdb_stall = 1'b0;
        chk("w_all_rcvd", 64'(rcvd), 64'(10));
        chk("w_end_cnt",  64'(i3.count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
